// File: rtl/player_move_ctrl.sv
// Player sprite movement controller: synchronized pushbuttons drive an IDLE/SLOW/FAST
// step FSM clocked by btnClk rising edges. Define PLAYER_WRAP_EN to wrap at screen edges instead of clamping.
module player_move_ctrl #(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int OBJ_W    = 16,
   parameter int OBJ_H    = 16,
   parameter int STEP     = 4,
   parameter int START_X  = 312,
   parameter int START_Y  = 232
) (
   input  logic       Clk_In,
   input  logic       rst,
   input  logic       btnClk,
   input  logic       btnU,
   input  logic       btnD,
   input  logic       btnL,
   input  logic       btnR,
   input  logic       btnC,
   output logic [9:0] posX,
   output logic [9:0] posY,
   output logic       moving,
   output logic       tick
);

   // state | meaning
   // IDLE  | no movement, run counter 0
   // SLOW  | moving STEP px per step, counting equal-direction steps
   // FAST  | moving 2*STEP px per step after four equal steps
   typedef enum logic [1:0] {ST_IDLE, ST_SLOW, ST_FAST} state_t;

   localparam logic signed [10:0] XMAX   = 11'(SCREEN_W - OBJ_W);
   localparam logic signed [10:0] YMAX   = 11'(SCREEN_H - OBJ_H);
   localparam logic signed [10:0] STEP_1 = 11'(STEP);
   localparam logic signed [10:0] STEP_2 = 11'(2 * STEP);
   localparam logic [9:0]         X0     = 10'(START_X);
   localparam logic [9:0]         Y0     = 10'(START_Y);

   state_t            state, state_nxt;
   logic [2:0]        run_cnt, run_cnt_nxt;
   logic [4:0]        btn_meta, btn_sync;       // {C, U, D, L, R}
   logic              btnClk_q;
   logic              step_ev;
   logic signed [1:0] dx, dy, prev_dx, prev_dy;
   logic signed [10:0] step_sz, off_x, off_y, nx, ny;
   logic [9:0]        posX_nxt, posY_nxt;
   logic              dir_zero, dir_same;

   function automatic logic [9:0] fit(input logic signed [10:0] v, input logic signed [10:0] vmax);
`ifdef PLAYER_WRAP_EN
      if (v < 11'sd0)     return vmax[9:0];
      else if (v > vmax)  return 10'd0;
      else                return v[9:0];
`else
      if (v < 11'sd0)     return 10'd0;
      else if (v > vmax)  return vmax[9:0];
      else                return v[9:0];
`endif
   endfunction

   assign step_ev = btnClk & ~btnClk_q;

   always_comb begin
      dx = 2'sd0;
      dy = 2'sd0;
      if (btn_sync[0] & ~btn_sync[1])      dx = 2'sd1;
      else if (btn_sync[1] & ~btn_sync[0]) dx = -2'sd1;
      if (btn_sync[2] & ~btn_sync[3])      dy = 2'sd1;
      else if (btn_sync[3] & ~btn_sync[2]) dy = -2'sd1;
      dir_zero = (dx == 2'sd0) && (dy == 2'sd0);
      dir_same = (dx == prev_dx) && (dy == prev_dy);
   end

   // State register plus the datapath registers that move with it
   always_ff @(posedge Clk_In) begin
      if (rst) begin
         btn_meta <= '0;
         btn_sync <= '0;
         btnClk_q <= 1'b1;
         tick     <= 1'b0;
         state    <= ST_IDLE;
         run_cnt  <= 3'd0;
         prev_dx  <= 2'sd0;
         prev_dy  <= 2'sd0;
         posX     <= X0;
         posY     <= Y0;
      end else begin
         btn_meta <= {btnC, btnU, btnD, btnL, btnR};
         btn_sync <= btn_meta;
         btnClk_q <= btnClk;
         tick     <= step_ev;
         if (btn_sync[4]) begin
            state   <= ST_IDLE;
            run_cnt <= 3'd0;
            prev_dx <= 2'sd0;
            prev_dy <= 2'sd0;
            posX    <= X0;
            posY    <= Y0;
         end else if (step_ev) begin
            state   <= state_nxt;
            run_cnt <= run_cnt_nxt;
            prev_dx <= dx;
            prev_dy <= dy;
            posX    <= posX_nxt;
            posY    <= posY_nxt;
         end
      end
   end

   // Next state; step size always follows the destination state
   always_comb begin
      state_nxt   = state;
      run_cnt_nxt = run_cnt;
      step_sz     = 11'sd0;
      if (dir_zero) begin
         state_nxt   = ST_IDLE;
         run_cnt_nxt = 3'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               state_nxt   = ST_SLOW;
               run_cnt_nxt = 3'd1;
               step_sz     = STEP_1;
            end
            ST_SLOW: begin
               if (dir_same && run_cnt >= 3'd4) begin
                  state_nxt = ST_FAST;
                  step_sz   = STEP_2;
               end else if (dir_same) begin
                  run_cnt_nxt = run_cnt + 3'd1;
                  step_sz     = STEP_1;
               end else begin
                  run_cnt_nxt = 3'd1;
                  step_sz     = STEP_1;
               end
            end
            ST_FAST: begin
               if (dir_same) begin
                  step_sz = STEP_2;
               end else begin
                  state_nxt   = ST_SLOW;
                  run_cnt_nxt = 3'd1;
                  step_sz     = STEP_1;
               end
            end
            default: begin
               state_nxt   = ST_IDLE;
               run_cnt_nxt = 3'd0;
            end
         endcase
      end
   end

   always_comb begin
      off_x = 11'sd0;
      off_y = 11'sd0;
      if (dx == 2'sd1)       off_x = step_sz;
      else if (dx == -2'sd1) off_x = -step_sz;
      if (dy == 2'sd1)       off_y = step_sz;
      else if (dy == -2'sd1) off_y = -step_sz;
      nx       = $signed({1'b0, posX}) + off_x;
      ny       = $signed({1'b0, posY}) + off_y;
      posX_nxt = fit(nx, XMAX);
      posY_nxt = fit(ny, YMAX);
   end

   always_comb begin
      moving = (state != ST_IDLE);
   end

endmodule
